fb_scene_rd_sched: RTL
======================

# fb_scene_rd_sched

Frame-aligned read scheduler for the SDRAM frame buffer on the HDMI side. It watches the game scene code and the display raster counters, and maps each scene to a stored background image window. On a scene change it flushes the SDRAM read FIFO path, waits for a settle period, and re-arms the read window exactly at a frame start. It sits between the game FSM / HDMI timing generator and the SDRAM controller's read port, and is the only driver of its reset, enable and address-window inputs.

## Interface
- `FRAME_START_H`, 100: hcnt value that marks the frame-start point.
- `FRAME_START_V`, 10: vcnt value that marks the frame-start point.
- `FLUSH_CYC`, 4: number of cycles `sdram_rst_n` is held low per flush, 1..255.
- `SETTLE_CYC`, 16: idle cycles after a flush before arming, 1..255.
- `IMG_WORDS`, 786432: words per stored image (1024×768).
- `hdmi_clk  in  1`: pixel clock; the only clock.
- `sys_rst_n  in  1`: asynchronous, active-low reset.
- `hcnt  in  12`: horizontal raster count.
- `vcnt  in  12`: vertical raster count.
- `state  in  4`: scene code. start=0001, gameplay=0010, pause=0100, gameover=1000, second=1010.
- `all_photo_en  in  1`: image load into SDRAM complete (level).
- `sdram_rst_n  out  1`: read-path reset to the SDRAM controller, active low.
- `sdram_rden  out  1`: read enable.
- `sdram_rd_b_addr  out  23`: read window begin address.
- `sdram_rd_e_addr  out  23`: read window end address (exclusive).
- `sched_busy  out  1`: high in any state other than IDLE or ACTIVE.

## Operation
- Image index map:
  - start → 0
  - gameplay → 1
  - pause → 1
  - gameover → 2
  - second → 2
  - any other code → none
- Window for an image: begin = idx·IMG_WORDS; end = begin+IMG_WORDS. All arithmetic is 23-bit and unsigned. Image 2 window = 1572864..2359296.
- `sof`: registered pulse, high for 1 cycle the cycle after hcnt==FRAME_START_H && vcnt==FRAME_START_V.
- `cur_scene` (4b): last committed scene. `pend` (4b): latest requested scene.
- FSM states:
  - **IDLE**: rden=0. Leaves when the mapped scene is valid and differs from `cur_scene`, or after reset. Goes to WAIT_SOF.
  - **WAIT_SOF**: on `sof`, latch `pend` into `cur_scene`, load the address registers, and go to FLUSH. If `pend` maps to none, go to IDLE instead.
  - **FLUSH**: `sdram_rst_n`=0 for FLUSH_CYC cycles, then go to SETTLE.
  - **SETTLE**: count SETTLE_CYC cycles, then go to ARM.
  - **ARM**: on `sof`, go to ACTIVE.
  - **ACTIVE**: `sdram_rden` = `all_photo_en`. Addresses are held.
- `pend` follows `state` every cycle. A scene change is detected when the mapped image of `pend` differs from that of `cur_scene` (gameplay↔pause produces no change).
- On a change in ACTIVE or ARM: rden drops the next cycle, go to WAIT_SOF.
- On a change in FLUSH or SETTLE: finish the current step, then go to WAIT_SOF rather than ARM.
- A change back to the already-committed image before WAIT_SOF exits: return to ARM (if the flush completed) or continue normally.
- Address outputs change only on WAIT_SOF→FLUSH.

## Timing
- Reset values:
  - `sdram_rst_n`=1
  - `sdram_rden`=0
  - b_addr=0, e_addr=0
  - `sched_busy`=0
  - `cur_scene`=0000
  - FSM = IDLE
- The first scene after reset always goes through a flush.
- Latency from the sof cycle: FLUSH entered at +1. `sdram_rst_n` low for cycles +1..+FLUSH_CYC. SETTLE for the next SETTLE_CYC cycles.
- rden rises the cycle after the first `sof` seen in ARM.
- `all_photo_en` low in ACTIVE forces rden=0 with no state change.
- Reset asserted mid-operation returns everything to the reset values immediately. No partial flush is resumed.
- All outputs are registered.

## Configuration
- `FB_SCHED_PAUSE_HOLD_EN` defined: pause keeps the window of the image currently committed, whatever it is. Entering or leaving pause never causes a flush, and rden stays high through pause.
- Not defined: pause maps statically to image 1. A change start→pause flushes and moves to image 1.

## Test plan
- Reset, then state=0001, all_photo_en=1 → at the first sof: b=0, e=786432, rst_n low 4 cycles, 16 settle cycles. rden=1 the cycle after the next sof.
- ACTIVE on image 0, state→0010 mid-frame → rden=0 next cycle. At the next sof: b=786432, e=1572864, flush, settle. rden=1 after the following sof.
- gameplay→pause→gameplay in ACTIVE → no flush, rden stays 1, addresses unchanged (both build modes when starting from image 1).
- state→1000 during SETTLE → settle completes, then WAIT_SOF. At the next sof: b=1572864, e=2359296 with a fresh flush.
- state=0011 (unmapped) → IDLE, rden=0, sched_busy=0, addresses held. all_photo_en toggling in ACTIVE → rden tracks it with 1-cycle latency.
- sys_rst_n pulsed low during FLUSH → rst_n=1, rden=0, addresses 0 immediately. A new full sequence starts at the next sof.

Source files
------------

// File: rtl/fb_scene_rd_sched_if.sv
// Bundles the raster/scene inputs and the SDRAM read-port controls of fb_scene_rd_sched.
// master: the scheduler itself; slave: the surrounding game FSM, HDMI timing and SDRAM controller.
interface fb_scene_rd_sched_if;
  logic [11:0] hcnt;
  logic [11:0] vcnt;
  logic [3:0]  state;
  logic        all_photo_en;
  logic        sdram_rst_n;
  logic        sdram_rden;
  logic [22:0] sdram_rd_b_addr;
  logic [22:0] sdram_rd_e_addr;
  logic        sched_busy;

  modport master (
    input  hcnt, vcnt, state, all_photo_en,
    output sdram_rst_n, sdram_rden, sdram_rd_b_addr, sdram_rd_e_addr, sched_busy
  );

  modport slave (
    output hcnt, vcnt, state, all_photo_en,
    input  sdram_rst_n, sdram_rden, sdram_rd_b_addr, sdram_rd_e_addr, sched_busy
  );
endinterface

// File: rtl/fb_scene_rd_sched.sv
// Frame-aligned SDRAM read scheduler: maps game scenes to image windows and re-arms reads at frame start.
// Optional macro FB_SCHED_PAUSE_HOLD_EN: pause keeps whatever image window is currently committed.
module fb_scene_rd_sched #(
  parameter int unsigned FRAME_START_H = 100,
  parameter int unsigned FRAME_START_V = 10,
  parameter int unsigned FLUSH_CYC     = 4,
  parameter int unsigned SETTLE_CYC    = 16,
  parameter int unsigned IMG_WORDS     = 786432
) (
  input logic               hdmi_clk,
  input logic               sys_rst_n,
  fb_scene_rd_sched_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SOF,
    FLUSH,
    SETTLE,
    ARM,
    ACTIVE
  } schedState_t;

  localparam logic [1:0]  IMG_NONE = 2'd3;
  localparam logic [22:0] IMG_W    = 23'(IMG_WORDS);
  localparam logic [22:0] BASE1    = 23'(IMG_WORDS);
  localparam logic [22:0] BASE2    = 23'(2 * IMG_WORDS);
  localparam logic [7:0]  FLUSH_LAST  = 8'(FLUSH_CYC - 1);
  localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYC - 1);

  function automatic logic [1:0] mapImg(input logic [3:0] code);
    case (code)
      4'b0001: mapImg = 2'd0;
      4'b0010: mapImg = 2'd1;
      4'b0100: mapImg = 2'd1;
      4'b1000: mapImg = 2'd2;
      4'b1010: mapImg = 2'd2;
      default: mapImg = IMG_NONE;
    endcase
  endfunction

  schedState_t state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  curScene_q, curScene_d;
  logic [3:0]  pend_q;
  logic        sof_q;
  logic [22:0] bAddr_q, bAddr_d;
  logic [22:0] eAddr_q, eAddr_d;
  logic        rstN_q;
  logic        rden_q;
  logic        busy_q;

  logic [1:0]  curImg;
  logic [1:0]  pendImg;
  logic        sceneChange;
  logic        pendValid;
  logic [22:0] winBase;

  // With pause-hold, a pause request simply inherits the committed image so it never looks like a change.
  always_comb begin
    curImg = mapImg(curScene_q);
`ifdef FB_SCHED_PAUSE_HOLD_EN
    pendImg = (pend_q == 4'b0100) ? curImg : mapImg(pend_q);
`else
    pendImg = mapImg(pend_q);
`endif
    sceneChange = (pendImg != curImg);
    pendValid   = (pendImg != IMG_NONE);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    curScene_d = curScene_q;
    bAddr_d    = bAddr_q;
    eAddr_d    = eAddr_q;
    winBase    = 23'd0;
    case (pendImg)
      2'd1:    winBase = BASE1;
      2'd2:    winBase = BASE2;
      default: winBase = 23'd0;
    endcase

    case (state_q)
      IDLE: begin
        if (pendValid && sceneChange) state_d = WAIT_SOF;
      end
      // A request that falls back to the committed image needs no new flush; the read path still holds it.
      WAIT_SOF: begin
        if (pendValid && !sceneChange) begin
          state_d = ARM;
        end else if (sof_q) begin
          if (!pendValid) begin
            state_d = IDLE;
          end else begin
            curScene_d = pend_q;
            bAddr_d    = winBase;
            eAddr_d    = winBase + IMG_W;
            cnt_d      = 8'd0;
            state_d    = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (cnt_q == FLUSH_LAST) begin
          cnt_d   = 8'd0;
          state_d = sceneChange ? WAIT_SOF : SETTLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = 8'd0;
          state_d = sceneChange ? WAIT_SOF : ARM;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ARM: begin
        if (sceneChange)  state_d = WAIT_SOF;
        else if (sof_q)   state_d = ACTIVE;
      end
      ACTIVE: begin
        if (sceneChange) state_d = WAIT_SOF;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output flops are loaded from the next state so every output is registered yet tracks the FSM exactly.
  always_ff @(posedge hdmi_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      curScene_q <= 4'b0000;
      pend_q     <= 4'b0000;
      sof_q      <= 1'b0;
      bAddr_q    <= 23'd0;
      eAddr_q    <= 23'd0;
      rstN_q     <= 1'b1;
      rden_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      curScene_q <= curScene_d;
      pend_q     <= bus.state;
      sof_q      <= (bus.hcnt == 12'(FRAME_START_H)) && (bus.vcnt == 12'(FRAME_START_V));
      bAddr_q    <= bAddr_d;
      eAddr_q    <= eAddr_d;
      rstN_q     <= (state_d != FLUSH);
      rden_q     <= (state_d == ACTIVE) && bus.all_photo_en;
      busy_q     <= !((state_d == IDLE) || (state_d == ACTIVE));
    end
  end

  assign bus.sdram_rst_n     = rstN_q;
  assign bus.sdram_rden      = rden_q;
  assign bus.sdram_rd_b_addr = bAddr_q;
  assign bus.sdram_rd_e_addr = eAddr_q;
  assign bus.sched_busy      = busy_q;

endmodule
